// File: rtl/enc_pkg.sv
// Shared types and sizes for the serialising 16-to-4 encoder.
// The optional out_last port is enabled by defining ENC_LAST_EN.
package enc_pkg;
   localparam int ENC_N = 16;
   localparam int ENC_W = $clog2(ENC_N);

   typedef enum logic {IDLE, DRAIN} enc_state_t;
   typedef logic [ENC_W-1:0] enc_idx_t;
endpackage

// File: rtl/prienc16.sv
// Combinational lowest-set-bit encoder: index of the lowest set line plus an any-bit flag.
// With no bit set the index reads 0, so q idles at 0.
module prienc16
   import enc_pkg::*;
(
   input  logic [ENC_N-1:0] vec,
   output enc_idx_t         idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      // scan downwards so the lowest set bit is the last one written
      for (int i = ENC_N - 1; i >= 0; i--) begin
         if (vec[i]) idx = ENC_W'(i);
      end
   end

   assign any = |vec;

endmodule

// File: rtl/encoder164.sv
// Serialising 16-to-4 encoder: emits the index of every set input line, lowest first.
// Define ENC_LAST_EN to add the out_last port marking the final index of a vector.
//
// state | meaning
// IDLE  | ready for a new line vector, no output pending
// DRAIN | emitting indices of pend, one per output handshake
module encoder164
   import enc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ENC_N-1:0] d,
   output logic             out_valid,
   input  logic             out_ready,
   output enc_idx_t         q,
   output logic             busy
`ifdef ENC_LAST_EN
   ,
   output logic             out_last
`endif
);

   enc_state_t       state, state_nxt;
   logic [ENC_N-1:0] pend, pend_nxt;
   logic [ENC_N-1:0] pend_clr;
   logic             pend_any;
   logic             last;

   prienc16 u_prienc (
      .vec (pend),
      .idx (q),
      .any (pend_any)
   );

   assign pend_clr = pend & (pend - 1'b1);
   // exactly one bit left: the current index is the final one of this vector
   assign last     = pend_any & ~(|pend_clr);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DRAIN);
   assign busy      = (state == DRAIN);

`ifdef ENC_LAST_EN
   assign out_last = out_valid & last;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      unique case (state)
         IDLE: begin
            if (in_valid && (d != '0)) begin
               pend_nxt  = d;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               pend_nxt = pend_clr;
               if (last) state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            pend_nxt  = '0;
         end
      endcase
   end

endmodule
